risc8_muldiv_seq: RTL and testbench



---
 rtl/risc8_muldiv_seq_pkg.sv | 84 ++++++++
 rtl/risc8_muldiv_seq_if.sv | 26 ++
 rtl/risc8_muldiv_seq.sv | 93 +++++++++
 tb/tb_risc8_muldiv_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/risc8_muldiv_seq_pkg.sv
// Shared definitions for the risc8 multiply/divide sequencer:
// ALU command encodings, muldiv_op bit positions, FSM states and the
// Moore output decode used by risc8_muldiv_seq.
package risc8_muldiv_seq_pkg;

  localparam int unsigned ITERS_DEF = 8;

  localparam logic [3:0] ALUadd = 4'h2;
  localparam logic [3:0] ALUtha = 4'hA;
  localparam logic [3:0] ALUthb = 4'hB;

  localparam int unsigned MD_MUL     = 0;
  localparam int unsigned MD_DIV     = 1;
  localparam int unsigned MD_INIT    = 2;
  localparam int unsigned MD_SAVE0   = 3;
  localparam int unsigned MD_SAVE1   = 4;
  localparam int unsigned MD_RESTORE = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_MUL     = 3'd2,
    ST_DIV     = 3'd3,
    ST_RESTORE = 3'd4,
    ST_SAVE0   = 3'd5,
    ST_SAVE1   = 3'd6,
    ST_TRAP    = 3'd7
  } seq_state_t;

  typedef struct packed {
    logic [5:0] muldiv_op;
    logic [3:0] alu_cmd;
    logic       alu_cmd_vld;
    logic       wb_lo;
    logic       wb_hi;
    logic       busy;
    logic       done;
    logic       div0_trap;
  } seq_out_t;

  // Output pattern for a given state; is_div only matters in INIT.
  function automatic seq_out_t seq_decode(input seq_state_t st, input logic is_div);
    seq_out_t o;
    o = '0;
    o.busy        = (st != ST_IDLE);
    o.alu_cmd_vld = (st != ST_IDLE);
    case (st)
      ST_INIT: begin
        o.muldiv_op[MD_INIT] = 1'b1;
        o.alu_cmd            = is_div ? ALUthb : ALUtha;
      end
      ST_MUL: begin
        o.muldiv_op[MD_MUL] = 1'b1;
        o.alu_cmd           = ALUadd;
      end
      ST_DIV: begin
        o.muldiv_op[MD_DIV] = 1'b1;
        o.alu_cmd           = ALUadd;
      end
      ST_RESTORE: begin
        o.muldiv_op[MD_RESTORE] = 1'b1;
        o.alu_cmd               = ALUadd;
      end
      ST_SAVE0: begin
        o.muldiv_op[MD_SAVE0] = 1'b1;
        o.alu_cmd             = ALUtha;
        o.wb_lo               = 1'b1;
      end
      ST_SAVE1: begin
        o.muldiv_op[MD_SAVE1] = 1'b1;
        o.alu_cmd             = ALUtha;
        o.wb_hi               = 1'b1;
        o.done                = 1'b1;
      end
      ST_TRAP: begin
        o.alu_cmd   = ALUtha;
        o.div0_trap = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/risc8_muldiv_seq_if.sv
// Request/ALU-control bundle between decode/execute and the mul/div sequencer.
// master: requesting stage plus ALU flag; slave: the sequencer.
interface risc8_muldiv_seq_if;
  logic       start_mul;
  logic       start_div;
  logic       divide_by_0;
  logic       flush;
  logic [5:0] muldiv_op;
  logic [3:0] alu_cmd;
  logic       alu_cmd_vld;
  logic       wb_lo;
  logic       wb_hi;
  logic       busy;
  logic       done;
  logic       div0_trap;

  modport master (
    output start_mul, start_div, divide_by_0, flush,
    input  muldiv_op, alu_cmd, alu_cmd_vld, wb_lo, wb_hi, busy, done, div0_trap
  );

  modport slave (
    input  start_mul, start_div, divide_by_0, flush,
    output muldiv_op, alu_cmd, alu_cmd_vld, wb_lo, wb_hi, busy, done, div0_trap
  );
endinterface

// File: rtl/risc8_muldiv_seq.sv
// risc8 multicycle multiply/divide sequencer. Drives the ALU's one-hot
// muldiv_op bus, command override and write-back strobes, and stalls the
// pipeline via busy until both result bytes are written back.
// Optional: define RISC8_MULDIV_FLUSH_EN to let flush abort an operation.
module risc8_muldiv_seq
  import risc8_muldiv_seq_pkg::*;
#(
  parameter int unsigned ITERS = ITERS_DEF,
  parameter int unsigned CNT_W = 3
) (
  input logic               clk,
  input logic               rst,
  risc8_muldiv_seq_if.slave bus
);

  seq_state_t       state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             is_div, nxt_is_div;
  logic             flush_act;
  seq_out_t         out_q;

`ifdef RISC8_MULDIV_FLUSH_EN
  assign flush_act = bus.flush;
`else
  logic unused_flush;
  assign unused_flush = bus.flush;
  assign flush_act    = 1'b0;
`endif

  // Next-state, iteration counter and operation-type selection.
  always_comb begin
    nxt_state  = state;
    nxt_cnt    = cnt;
    nxt_is_div = is_div;
    case (state)
      ST_IDLE: begin
        if (!flush_act && (bus.start_mul || bus.start_div)) begin
          nxt_state  = ST_INIT;
          nxt_is_div = !bus.start_mul;
        end
      end
      ST_INIT: begin
        nxt_cnt = CNT_W'(ITERS - 1);
        if (is_div && bus.divide_by_0) nxt_state = ST_TRAP;
        else if (is_div)               nxt_state = ST_DIV;
        else                           nxt_state = ST_MUL;
      end
      ST_MUL: begin
        if (cnt == '0) nxt_state = ST_SAVE0;
        else           nxt_cnt   = cnt - CNT_W'(1);
      end
      ST_DIV: begin
        if (cnt == '0) nxt_state = ST_RESTORE;
        else           nxt_cnt   = cnt - CNT_W'(1);
      end
      ST_RESTORE: nxt_state = ST_SAVE0;
      ST_SAVE0:   nxt_state = ST_SAVE1;
      ST_SAVE1:   nxt_state = ST_IDLE;
      ST_TRAP:    nxt_state = ST_IDLE;
      default:    nxt_state = ST_IDLE;
    endcase
    if (flush_act && state != ST_IDLE) nxt_state = ST_IDLE;
  end

  // State register; outputs are registered by decoding the next state so
  // each output is a flop yet still follows the Moore table of the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      out_q  <= '0;
    end else begin
      state  <= nxt_state;
      cnt    <= nxt_cnt;
      is_div <= nxt_is_div;
      out_q  <= seq_decode(nxt_state, nxt_is_div);
    end
  end

  assign bus.muldiv_op   = out_q.muldiv_op;
  assign bus.alu_cmd     = out_q.alu_cmd;
  assign bus.alu_cmd_vld = out_q.alu_cmd_vld;
  assign bus.wb_lo       = out_q.wb_lo;
  assign bus.wb_hi       = out_q.wb_hi;
  assign bus.busy        = out_q.busy;
  assign bus.done        = out_q.done;
  assign bus.div0_trap   = out_q.div0_trap;

  // The ALU selects from muldiv_op one-hot; two bits at once corrupts the datapath.
  a_muldiv_op_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.muldiv_op));

endmodule

// File: tb/tb_risc8_muldiv_seq.sv
// Scoreboard bench for risc8_muldiv_seq with a small shift/add,
// non-restoring-divide ALU model driven by the sequencer's muldiv_op bus.
module tb_risc8_muldiv_seq;
  import risc8_muldiv_seq_pkg::*;

  localparam int EV_LO = 0, EV_HI = 1, EV_DONE = 2, EV_TRAP = 3;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  ev_t  sb[$];

  logic [7:0] op_a = '0, op_b = '0;
  logic [9:0] m_a = '0;
  logic [7:0] m_q = '0, m_m = '0;
  logic [8:0] mul_sum;
  logic [9:0] dv_sh, dv_na;
  logic [7:0] alu_y;

  risc8_muldiv_seq_if bus ();

  risc8_muldiv_seq #(.ITERS(8), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.divide_by_0 = (op_b == 8'd0);

  // ALU model: state lives in {m_a, m_q}, divisor/multiplicand in m_m.
  assign mul_sum = {1'b0, m_a[7:0]} + (m_q[0] ? {1'b0, m_m} : 9'd0);
  assign dv_sh   = {m_a[8:0], m_q[7]};
  assign dv_na   = m_a[9] ? dv_sh + {2'b00, m_m} : dv_sh - {2'b00, m_m};
  assign alu_y   = bus.muldiv_op[MD_SAVE0] ? m_q : m_a[7:0];

  always @(posedge clk) begin
    if (bus.muldiv_op[MD_INIT]) begin
      m_a <= '0;
      m_q <= op_a;
      m_m <= op_b;
    end else if (bus.muldiv_op[MD_MUL]) begin
      m_a <= {2'b00, mul_sum[8:1]};
      m_q <= {mul_sum[0], m_q[7:1]};
    end else if (bus.muldiv_op[MD_DIV]) begin
      m_a <= dv_na;
      m_q <= {m_q[6:0], ~dv_na[9]};
    end else if (bus.muldiv_op[MD_RESTORE]) begin
      if (m_a[9]) m_a <= m_a + {2'b00, m_m};
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] data);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d data %0h expected none (cycle %0d)", kind, data, cyc);
    end else begin
      e = sb.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_data", {24'd0, data}, {24'd0, e.data});
      chk("ev_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: every strobe from the DUT must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      chk("onehot0", {31'd0, $onehot0(bus.muldiv_op)}, 32'd1);
      if (bus.wb_lo)     expect_ev(EV_LO, alu_y);
      if (bus.wb_hi)     expect_ev(EV_HI, alu_y);
      if (bus.done)      expect_ev(EV_DONE, 8'd0);
      if (bus.div0_trap) expect_ev(EV_TRAP, 8'd0);
    end
  end

  task automatic push_result(input int c, input bit dv, input logic [7:0] lo, input logic [7:0] hi);
    int n;
    n = dv ? 12 : 11;
    sb.push_back('{EV_LO, lo, c + n - 1});
    sb.push_back('{EV_HI, hi, c + n});
    sb.push_back('{EV_DONE, 8'd0, c + n});
  endtask

  task automatic wait_idle(input int c, input int rel);
    int k;
    k = 0;
    while (bus.busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (bus.busy) chk("idle_timeout", 32'd1, 32'd0);
    else begin
      chk("idle_cycle", cyc - c, rel);
      chk("idle_cmd", {28'd0, bus.alu_cmd}, 32'd0);
    end
  endtask

  task automatic run_op(input bit dv, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] lo, input logic [7:0] hi);
    int c;
    @(negedge clk);
    op_a = a;
    op_b = b;
    if (dv) bus.start_div = 1'b1;
    else    bus.start_mul = 1'b1;
    c = cyc;
    if (dv && b == 8'd0) sb.push_back('{EV_TRAP, 8'd0, c + 2});
    else                 push_result(c, dv, lo, hi);
    @(negedge clk);
    bus.start_mul = 1'b0;
    bus.start_div = 1'b0;
    chk("init_busy", {31'd0, bus.busy}, 32'd1);
    chk("init_op", {26'd0, bus.muldiv_op}, 32'h04);
    chk("init_cmd", {28'd0, bus.alu_cmd}, dv ? {28'd0, ALUthb} : {28'd0, ALUtha});
    chk("init_vld", {31'd0, bus.alu_cmd_vld}, 32'd1);
    wait_idle(c, (dv && b == 8'd0) ? 3 : (dv ? 13 : 12));
  endtask

  initial begin
    int c;
    bus.start_mul = 1'b0;
    bus.start_div = 1'b0;
    bus.flush     = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_op", {26'd0, bus.muldiv_op}, 32'd0);
    chk("rst_cmd", {27'd0, bus.alu_cmd, bus.alu_cmd_vld}, 32'd0);
    chk("rst_strobes", {28'd0, bus.wb_lo, bus.wb_hi, bus.done, bus.div0_trap}, 32'd0);

    // Directed vectors: {div, a, b, lo, hi}
    run_op(1'b0, 8'hFF, 8'hFF, 8'h01, 8'hFE);
    run_op(1'b1, 8'd200, 8'd7, 8'd28, 8'd4);
    run_op(1'b1, 8'd5, 8'd0, 8'd0, 8'd0);
    run_op(1'b0, 8'h0F, 8'h10, 8'hF0, 8'h00);
    run_op(1'b1, 8'hFF, 8'h01, 8'hFF, 8'h00);
    run_op(1'b0, 8'h00, 8'hC3, 8'h00, 8'h00);
    run_op(1'b1, 8'd7, 8'd200, 8'd0, 8'd7);

    // Simultaneous requests: mul first (200*7 = 0x0578), div held until after done.
    @(negedge clk);
    op_a = 8'd200;
    op_b = 8'd7;
    bus.start_mul = 1'b1;
    bus.start_div = 1'b1;
    c = cyc;
    push_result(c, 1'b0, 8'h78, 8'h05);
    sb.push_back('{EV_LO, 8'd28, c + 23});
    sb.push_back('{EV_HI, 8'd4, c + 24});
    sb.push_back('{EV_DONE, 8'd0, c + 24});
    @(negedge clk);
    bus.start_mul = 1'b0;
    chk("both_init_cmd", {28'd0, bus.alu_cmd}, {28'd0, ALUtha});
    repeat (11) @(negedge clk);
    chk("both_gap_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    chk("both_div_init", {26'd0, bus.muldiv_op}, 32'h04);
    chk("both_div_cmd", {28'd0, bus.alu_cmd}, {28'd0, ALUthb});
    bus.start_div = 1'b0;
    wait_idle(c, 25);

    // Reset in the 4th MUL cycle: nothing may be written back.
    @(negedge clk);
    op_a = 8'd3;
    op_b = 8'd5;
    bus.start_mul = 1'b1;
    c = cyc;
    @(negedge clk);
    bus.start_mul = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst4_in_mul", {26'd0, bus.muldiv_op}, 32'h01);
    rst = 1'b1;
    @(negedge clk);
    chk("rst4_cycle", cyc - c, 32'd6);
    chk("rst4_outputs", {16'd0, bus.muldiv_op, bus.alu_cmd, bus.alu_cmd_vld, bus.wb_lo,
                         bus.wb_hi, bus.busy, bus.done, bus.div0_trap}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_op(1'b0, 8'd3, 8'd5, 8'h0F, 8'h00);

    // Flush during RESTORE.
    @(negedge clk);
    op_a = 8'd200;
    op_b = 8'd7;
    bus.start_div = 1'b1;
    c = cyc;
`ifndef RISC8_MULDIV_FLUSH_EN
    push_result(c, 1'b1, 8'd28, 8'd4);
`endif
    @(negedge clk);
    bus.start_div = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush_in_restore", {26'd0, bus.muldiv_op}, 32'h20);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
`ifdef RISC8_MULDIV_FLUSH_EN
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
`else
    wait_idle(c, 13);
`endif

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
